// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped read cache.
package cache_pkg;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned LINES    = 16;
    localparam int unsigned OFFSET_W = 2;
    localparam int unsigned INDEX_W  = 4;
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned STAT_W   = 16;

    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [INDEX_W-1:0] index_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        RESPOND,
        FLUSH
    } state_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/cache_controller_if.sv
// CPU request/response, flush and refill signals of the cache controller.
interface cache_controller_if;
    logic        iReqValid;
    logic [31:0] iReqAddr;
    logic        oReqReady;
    logic        oRspValid;
    logic [31:0] oRspData;
    logic        oRspErr;
    logic        iFlush;
    logic [31:0] iFlushAddress;
    logic        oFlushAck;
    logic        oMemReq;
    logic [31:0] oMemAddr;
    logic        iMemValid;
    logic [31:0] iMemData;
    logic [15:0] oHitCount;
    logic [15:0] oMissCount;

    modport slave (
        input  iReqValid, iReqAddr, iFlush, iFlushAddress, iMemValid, iMemData,
        output oReqReady, oRspValid, oRspData, oRspErr, oFlushAck, oMemReq, oMemAddr,
               oHitCount, oMissCount
    );

    modport master (
        output iReqValid, iReqAddr, iFlush, iFlushAddress, iMemValid, iMemData,
        input  oReqReady, oRspValid, oRspData, oRspErr, oFlushAck, oMemReq, oMemAddr,
               oHitCount, oMissCount
    );
endinterface

// File: rtl/cache_array.sv
// Valid/tag/data storage: combinational read port, one write port.
// A write with wr_valid=0 only invalidates the line.
module cache_array
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  index_t            rd_index,
    output logic              rd_valid,
    output tag_t              rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  index_t            wr_index,
    input  logic              wr_valid,
    input  tag_t              wr_tag,
    input  logic [DATA_W-1:0] wr_data
);
    logic [LINES-1:0]  valid;
    tag_t              tags [LINES];
    logic [DATA_W-1:0] data [LINES];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_valid) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped 16-line read cache controller with refill timeout,
// single-line flush and saturating hit/miss statistics.
module cache_controller
    import cache_pkg::*;
#(
    parameter int unsigned REFILL_TIMEOUT = 255
) (
    input logic         iClk,
    input logic         iRst,
    cache_controller_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(REFILL_TIMEOUT + 1);

    state_t                   state, state_next;
    logic [ADDR_W-1:OFFSET_W] req_word;
    logic [DATA_W-1:0]        rsp_data;
    logic                     rsp_err;
    logic [CNT_W-1:0]         refill_cnt;
    logic [STAT_W-1:0]        hit_cnt, miss_cnt;

    tag_t              req_tag, flush_tag, rd_tag;
    index_t            req_index, flush_index, rd_index;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              hit, flush_match, timeout, wr_en, wr_valid;
    logic              unused_offsets;

    assign req_tag        = req_word[ADDR_W-1 -: TAG_W];
    assign req_index      = req_word[OFFSET_W +: INDEX_W];
    assign flush_tag      = bus.iFlushAddress[ADDR_W-1 -: TAG_W];
    assign flush_index    = bus.iFlushAddress[OFFSET_W +: INDEX_W];
    assign unused_offsets = ^{bus.iReqAddr[OFFSET_W-1:0], bus.iFlushAddress[OFFSET_W-1:0]};

    // The single read port is shared: flush probes its own index, everything else the request's.
    assign rd_index    = (state == FLUSH) ? flush_index : req_index;
    assign hit         = rd_valid && (rd_tag == req_tag);
    assign flush_match = rd_valid && (rd_tag == flush_tag);
    assign timeout     = (refill_cnt == CNT_W'(REFILL_TIMEOUT - 1));

    cache_array u_array (
        .clk      (iClk),
        .rst_n    (iRst),
        .rd_index (rd_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (rd_index),
        .wr_valid (wr_valid),
        .wr_tag   (req_tag),
        .wr_data  (bus.iMemData)
    );

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.iFlush)         state_next = FLUSH;
                else if (bus.iReqValid) state_next = LOOKUP;
            end
            LOOKUP:  state_next = hit ? RESPOND : REFILL;
            REFILL: begin
                if (bus.iMemValid) begin
                    wr_en      = 1'b1;
                    wr_valid   = 1'b1;
                    state_next = RESPOND;
                end else if (timeout) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: state_next = IDLE;
            FLUSH: begin
                wr_en      = flush_match;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            req_word   <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            refill_cnt <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    refill_cnt <= '0;
                    if (!bus.iFlush && bus.iReqValid) req_word <= bus.iReqAddr[ADDR_W-1:OFFSET_W];
                end
                LOOKUP: begin
                    refill_cnt <= '0;
                    if (hit) begin
                        rsp_data <= rd_data;
                        rsp_err  <= 1'b0;
                        hit_cnt  <= sat_inc(hit_cnt);
                    end else begin
                        miss_cnt <= sat_inc(miss_cnt);
                    end
                end
                REFILL: begin
                    if (bus.iMemValid) begin
                        rsp_data <= bus.iMemData;
                        rsp_err  <= 1'b0;
                    end else if (timeout) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        refill_cnt <= refill_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.oReqReady  = iRst && (state == IDLE) && !bus.iFlush;
    assign bus.oRspValid  = (state == RESPOND);
    assign bus.oRspData   = rsp_data;
    assign bus.oRspErr    = (state == RESPOND) && rsp_err;
    assign bus.oFlushAck  = (state == FLUSH);
    assign bus.oMemReq    = (state == REFILL);
    assign bus.oMemAddr   = {req_word, {OFFSET_W{1'b0}}};
    assign bus.oHitCount  = hit_cnt;
    assign bus.oMissCount = miss_cnt;
endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller.
module tb_cache_controller;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [31:0]  d, ma;
    logic         e, ok;
    int unsigned  lat, rc, acks, seen;

    cache_controller_if bus ();

    cache_controller #(.REFILL_TIMEOUT(255)) dut (
        .iClk (clk),
        .iRst (rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one read; iMemValid is raised on the mem_delay-th REFILL cycle (0 = never driven).
    task automatic do_read(input logic [31:0] addr, input int unsigned mem_delay, input logic [31:0] mem_word,
                           output logic [31:0] data, output logic err, output int unsigned latency,
                           output int unsigned refill_cycles, output logic [31:0] mem_addr, output logic done);
        done = 1'b0; data = '0; err = 1'b0; latency = 0; refill_cycles = 0; mem_addr = '0;
        @(negedge clk);
        bus.iReqValid = 1'b1;
        bus.iReqAddr  = addr;
        for (int i = 0; i < 20 && !bus.oReqReady; i++) @(negedge clk);
        if (!bus.oReqReady) begin
            bus.iReqValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.iReqValid = 1'b0;
        for (int unsigned c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (bus.oMemReq) begin
                refill_cycles++;
                mem_addr = bus.oMemAddr;
            end
            if (mem_delay != 0) begin
                bus.iMemValid = bus.oMemReq && (refill_cycles == mem_delay);
                bus.iMemData  = mem_word;
            end
            if (bus.oRspValid) begin
                data    = bus.oRspData;
                err     = bus.oRspErr;
                latency = c;
                done    = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_flush(input logic [31:0] addr, output int unsigned ack_count, output logic done);
        ack_count = 0; done = 1'b0;
        @(negedge clk);
        bus.iFlush        = 1'b1;
        bus.iFlushAddress = addr;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.oFlushAck) begin
                ack_count++;
                done       = 1'b1;
                bus.iFlush = 1'b0;
            end
        end
        bus.iFlush = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.iReqValid = 1'b0; bus.iReqAddr = '0; bus.iFlush = 1'b0; bus.iFlushAddress = '0;
        bus.iMemValid = 1'b0; bus.iMemData = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.oReqReady !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.oReqReady); end
        checks++; if (bus.oMemReq !== 1'b0 || bus.oRspValid !== 1'b0 || bus.oFlushAck !== 1'b0 || bus.oRspErr !== 1'b0) begin
            failures++; $display("FAIL rst_ctrl memreq=%b rspv=%b ack=%b err=%b exp=0", bus.oMemReq, bus.oRspValid, bus.oFlushAck, bus.oRspErr); end
        checks++; if (bus.oHitCount !== 16'd0 || bus.oMissCount !== 16'd0) begin
            failures++; $display("FAIL rst_counts hit=%0d miss=%0d exp=0", bus.oHitCount, bus.oMissCount); end
        checks++; if (bus.oRspData !== 32'd0 || bus.oMemAddr !== 32'd0) begin
            failures++; $display("FAIL rst_data data=%h addr=%h exp=0", bus.oRspData, bus.oMemAddr); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.oReqReady !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", bus.oReqReady); end
    endtask

    task automatic test_cold_miss;
        do_read(32'h0000_0040, 2, 32'hDEAD_BEEF, d, e, lat, rc, ma, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL cold_rsp got=no_response exp=response"); end
        checks++; if (ma !== 32'h0000_0040) begin failures++; $display("FAIL cold_memaddr got=%h exp=00000040", ma); end
        checks++; if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin failures++; $display("FAIL cold_data got=%h err=%b exp=deadbeef err=0", d, e); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL cold_latency got=%0d exp=4", lat); end
        checks++; if (bus.oMissCount !== 16'd1 || bus.oHitCount !== 16'd0) begin
            failures++; $display("FAIL cold_counts hit=%0d miss=%0d exp hit=0 miss=1", bus.oHitCount, bus.oMissCount); end
        @(negedge clk);
        checks++; if (bus.oRspValid !== 1'b0) begin failures++; $display("FAIL cold_pulse got=%b exp=0", bus.oRspValid); end
    endtask

    task automatic test_hit;
        // Stray memory data during a hit must not reach the response.
        bus.iMemValid = 1'b1; bus.iMemData = 32'h1234_5678;
        do_read(32'h0000_0040, 0, 32'h0, d, e, lat, rc, ma, ok);
        bus.iMemValid = 1'b0;
        checks++; if (ok !== 1'b1 || lat !== 2) begin failures++; $display("FAIL hit_latency got=%0d ok=%b exp=2", lat, ok); end
        checks++; if (rc !== 0) begin failures++; $display("FAIL hit_memreq got=%0d exp=0", rc); end
        checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL hit_data got=%h exp=deadbeef", d); end
        checks++; if (bus.oHitCount !== 16'd1 || bus.oMissCount !== 16'd1) begin
            failures++; $display("FAIL hit_counts hit=%0d miss=%0d exp hit=1 miss=1", bus.oHitCount, bus.oMissCount); end
        do_read(32'h0000_0043, 0, 32'h0, d, e, lat, rc, ma, ok);
        checks++; if (d !== 32'hDEAD_BEEF || rc !== 0 || bus.oHitCount !== 16'd2) begin
            failures++; $display("FAIL hit_offset data=%h refill=%0d hit=%0d exp deadbeef 0 2", d, rc, bus.oHitCount); end
    endtask

    task automatic test_conflict;
        do_read(32'h0000_0080, 1, 32'hCAFE_F00D, d, e, lat, rc, ma, ok);
        checks++; if (ma !== 32'h0000_0080 || d !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL conflict_fill addr=%h data=%h exp 00000080 cafef00d", ma, d); end
        do_read(32'h0000_0040, 1, 32'hDEAD_BEEF, d, e, lat, rc, ma, ok);
        checks++; if (rc === 0 || ma !== 32'h0000_0040 || d !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL conflict_remiss refill=%0d addr=%h data=%h exp >0 00000040 deadbeef", rc, ma, d); end
        checks++; if (bus.oMissCount !== 16'd3 || bus.oHitCount !== 16'd2) begin
            failures++; $display("FAIL conflict_counts hit=%0d miss=%0d exp hit=2 miss=3", bus.oHitCount, bus.oMissCount); end
    endtask

    task automatic test_flush;
        do_flush(32'h0000_1040, acks, ok);
        checks++; if (acks !== 1) begin failures++; $display("FAIL flush_mismatch_ack got=%0d exp=1", acks); end
        do_read(32'h0000_0040, 0, 32'h0, d, e, lat, rc, ma, ok);
        checks++; if (ok !== 1'b1 || rc !== 0 || d !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL flush_mismatch_kept refill=%0d data=%h exp 0 deadbeef", rc, d); end
        do_flush(32'h0000_0040, acks, ok);
        checks++; if (acks !== 1) begin failures++; $display("FAIL flush_ack got=%0d exp=1", acks); end
        do_read(32'h0000_0040, 1, 32'h1111_2222, d, e, lat, rc, ma, ok);
        checks++; if (rc === 0 || d !== 32'h1111_2222) begin
            failures++; $display("FAIL flush_invalidated refill=%0d data=%h exp >0 11112222", rc, d); end
        checks++; if (bus.oMissCount !== 16'd4 || bus.oHitCount !== 16'd3) begin
            failures++; $display("FAIL flush_counts hit=%0d miss=%0d exp hit=3 miss=4", bus.oHitCount, bus.oMissCount); end
    endtask

    task automatic test_timeout;
        do_read(32'h0000_0100, 0, 32'h0, d, e, lat, rc, ma, ok);
        checks++; if (ok !== 1'b1 || e !== 1'b1 || d !== 32'd0) begin
            failures++; $display("FAIL timeout_rsp ok=%b err=%b data=%h exp 1 1 0", ok, e, d); end
        checks++; if (rc !== 255 || lat !== 257) begin failures++; $display("FAIL timeout_cycles got=%0d lat=%0d exp 255 257", rc, lat); end
        do_read(32'h0000_0040, 0, 32'h0, d, e, lat, rc, ma, ok);
        checks++; if (rc !== 0 || d !== 32'h1111_2222 || e !== 1'b0) begin
            failures++; $display("FAIL timeout_line_kept refill=%0d data=%h err=%b exp 0 11112222 0", rc, d, e); end
        checks++; if (bus.oMissCount !== 16'd5 || bus.oHitCount !== 16'd4) begin
            failures++; $display("FAIL timeout_counts hit=%0d miss=%0d exp hit=4 miss=5", bus.oHitCount, bus.oMissCount); end
    endtask

    task automatic test_priority;
        @(negedge clk);
        bus.iFlush = 1'b1; bus.iFlushAddress = 32'h0;
        bus.iReqValid = 1'b1; bus.iReqAddr = 32'h0000_0044;
        #1;
        checks++; if (bus.oReqReady !== 1'b0) begin failures++; $display("FAIL prio_ready got=%b exp=0", bus.oReqReady); end
        @(posedge clk); #1;
        checks++; if (bus.oFlushAck !== 1'b1 || bus.oReqReady !== 1'b0) begin
            failures++; $display("FAIL prio_flush_first ack=%b ready=%b exp 1 0", bus.oFlushAck, bus.oReqReady); end
        bus.iFlush = 1'b0; bus.iReqValid = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.oFlushAck !== 1'b0 || bus.oMissCount !== 16'd5 || bus.oHitCount !== 16'd4) begin
            failures++; $display("FAIL prio_no_accept ack=%b hit=%0d miss=%0d exp 0 4 5", bus.oFlushAck, bus.oHitCount, bus.oMissCount); end
        do_read(32'h0000_0044, 2, 32'h4444_0044, d, e, lat, rc, ma, ok);
        checks++; if (ma !== 32'h0000_0044 || d !== 32'h4444_0044 || bus.oMissCount !== 16'd6) begin
            failures++; $display("FAIL prio_read addr=%h data=%h miss=%0d exp 00000044 44440044 6", ma, d, bus.oMissCount); end
    endtask

    task automatic test_reset_mid_refill;
        @(negedge clk);
        bus.iReqValid = 1'b1; bus.iReqAddr = 32'h0000_0200;
        @(posedge clk); #1 bus.iReqValid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.oMemReq !== 1'b1) begin failures++; $display("FAIL midrst_refill got=%b exp=1", bus.oMemReq); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.oMemReq !== 1'b0 || bus.oRspValid !== 1'b0 || bus.oReqReady !== 1'b0) begin
            failures++; $display("FAIL midrst_async memreq=%b rspv=%b ready=%b exp 0 0 0", bus.oMemReq, bus.oRspValid, bus.oReqReady); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.oRspValid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_rsp got=%0d exp=0", seen); end
        checks++; if (bus.oHitCount !== 16'd0 || bus.oMissCount !== 16'd0) begin
            failures++; $display("FAIL midrst_counts hit=%0d miss=%0d exp=0", bus.oHitCount, bus.oMissCount); end
        do_read(32'h0000_0040, 1, 32'h5555_AAAA, d, e, lat, rc, ma, ok);
        checks++; if (rc === 0 || ma !== 32'h0000_0040 || d !== 32'h5555_AAAA || bus.oMissCount !== 16'd1) begin
            failures++; $display("FAIL midrst_cleared refill=%0d addr=%h data=%h miss=%0d exp >0 00000040 5555aaaa 1", rc, ma, d, bus.oMissCount); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_cold_miss;
        test_hit;
        test_conflict;
        test_flush;
        test_timeout;
        test_priority;
        test_reset_mid_refill;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
